scroll_sequencer: RTL and testbench

Controller that sequences the sliding-window counter of the text display. It generates the `tick_slide` and `scroll_en` strobes that the window counter consumes, and implements run / pause / single-step / stop control from debounced button pulses. It also provides selectable scroll speed and a bounded number of full-message loops. It sits between the button-conditioning logic and the window counter, and reads back the counter's `win_idx` to detect loop completion.

---
 rtl/scroll_sequencer.sv | 122 ++++++++++++
 tb/tb_scroll_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scroll_sequencer.sv
// rtl/scroll_sequencer.sv - run/pause/step/stop sequencer for the scrolling window counter
module scroll_sequencer #(
  parameter int BASE_DIV   = 6250000,
  parameter int MSG_LEN    = 12,
  parameter int LOOPS      = 3,
  parameter int INIT_SPEED = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       pause_p,
  input  logic       step_p,
  input  logic       speed_up_p,
  input  logic       speed_dn_p,
  input  logic [3:0] win_idx,
  output logic       tick_slide,
  output logic       scroll_en,
  output logic       done,
  output logic [1:0] state,
  output logic [1:0] speed,
  output logic [7:0] loop_cnt
);

  localparam int PW = $clog2(8 * BASE_DIV);
  localparam logic [PW:0] BD = (PW + 1)'(BASE_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t        st_q, st_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW:0]   period_m1;
  logic [1:0]    speed_d;
  logic [7:0]    loop_d;
  logic          tick_d, step_d, wrap, last_loop, up_ok, dn_ok, at_last;

  assign state = st_q;

  always_comb begin
    period_m1 = (BD << (2'd3 - speed)) - 1'b1;
    at_last   = ({1'b0, presc_q} == period_m1);
    up_ok     = speed_up_p && !speed_dn_p && (speed != 2'd3);
    dn_ok     = speed_dn_p && !speed_up_p && (speed != 2'd0);
    wrap      = tick_slide && scroll_en && (win_idx == 4'(MSG_LEN - 1));

    st_d    = st_q;
    presc_d = presc_q;
    speed_d = speed;
    loop_d  = loop_cnt;
    tick_d  = 1'b0;
    step_d  = 1'b0;

    if (wrap && loop_cnt != 8'hff)
      loop_d = loop_cnt + 8'd1;
    last_loop = wrap && (LOOPS != 0) && (loop_d == 8'(LOOPS));

    case (st_q)
      IDLE, DONE: begin
        presc_d = '0;
        if (start_p) begin
          st_d   = RUN;
          loop_d = 8'd0;
        end
      end
      RUN: begin
        if (last_loop)
          st_d = DONE;
        else if (pause_p)
          st_d = PAUSE;
        else if (at_last) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else
          presc_d = presc_q + 1'b1;
      end
      PAUSE: begin
        if (last_loop)
          st_d = DONE;
        else if (pause_p)
          st_d = RUN;
        else if (step_p)
          step_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase

    if (stop_p) begin
      st_d    = IDLE;
      presc_d = '0;
      tick_d  = 1'b0;
      step_d  = 1'b0;
    end

    // A real speed change restarts the period; a saturated request is a no-op
    if (up_ok || dn_ok) begin
      speed_d = up_ok ? speed + 2'd1 : speed - 2'd1;
      presc_d = '0;
      tick_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      presc_q    <= '0;
      speed      <= 2'(INIT_SPEED);
      loop_cnt   <= 8'd0;
      tick_slide <= 1'b0;
      scroll_en  <= 1'b0;
      done       <= 1'b0;
    end else begin
      st_q       <= st_d;
      presc_q    <= presc_d;
      speed      <= speed_d;
      loop_cnt   <= loop_d;
      tick_slide <= tick_d || step_d;
      scroll_en  <= (st_d == RUN) || step_d;
      done       <= (st_d == DONE);
    end
  end

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb/tb_scroll_sequencer.sv - directed self-checking bench for scroll_sequencer
`define CHK(tag, obs, exp) \
  begin \
    n_cmp++; \
    assert ((obs) === (exp)) else begin \
      n_err++; \
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
    end \
  end

module tb_scroll_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_p = 1'b0, stop_p = 1'b0, pause_p = 1'b0, step_p = 1'b0;
  logic       speed_up_p = 1'b0, speed_dn_p = 1'b0;
  logic [3:0] win_idx;
  logic       tick_slide, scroll_en, done;
  logic [1:0] state, speed;
  logic [7:0] loop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] ST = 6'b100000, SP = 6'b010000, PA = 6'b001000,
                         STEP = 6'b000100, UP = 6'b000010, DN = 6'b000001;

  scroll_sequencer #(.BASE_DIV(4), .MSG_LEN(12), .LOOPS(2), .INIT_SPEED(3)) dut (
    .clk(clk), .rst(rst), .start_p(start_p), .stop_p(stop_p), .pause_p(pause_p),
    .step_p(step_p), .speed_up_p(speed_up_p), .speed_dn_p(speed_dn_p), .win_idx(win_idx),
    .tick_slide(tick_slide), .scroll_en(scroll_en), .done(done), .state(state),
    .speed(speed), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural window counter wrapping at MSG_LEN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      win_idx <= 4'd0;
    else if (tick_slide && scroll_en)
      win_idx <= (win_idx == 4'd11) ? 4'd0 : win_idx + 4'd1;
  end

  task automatic pulse(input logic [5:0] m);
    {start_p, stop_p, pause_p, step_p, speed_up_p, speed_dn_p} = m;
    @(negedge clk);
    {start_p, stop_p, pause_p, step_p, speed_up_p, speed_dn_p} = 6'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_slide && n < 100);
  endtask

  task automatic count_ticks(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tick_slide) k++;
    end
  endtask

  task automatic step_once;
    pulse(STEP);
    `CHK("step_tick", {tick_slide, scroll_en}, 2'b11)
    @(negedge clk);
    `CHK("step_single", tick_slide, 1'b0)
  endtask

  initial begin
    int n, k, bad;
    logic [3:0] w0;

    // 1. reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_ticks(50, k);
    `CHK("idle_ticks", k, 0)
    `CHK("rst_state", state, 2'd0)
    `CHK("rst_flags", {tick_slide, scroll_en, done}, 3'b000)
    `CHK("rst_speed", speed, 2'd3)
    `CHK("rst_loop", loop_cnt, 8'd0)

    // 2. start and first ticks
    pulse(ST);
    `CHK("start_state", state, 2'd1)
    `CHK("start_en", scroll_en, 1'b1)
    wait_tick(n);
    `CHK("first_tick", n, 4)
    `CHK("first_win", win_idx, 4'd0)
    wait_tick(n);
    `CHK("second_tick", n, 4)
    `CHK("second_win", win_idx, 4'd1)
    wait_tick(n);
    `CHK("third_win", win_idx, 4'd2)

    // mid-run asynchronous reset
    @(negedge clk);
    rst = 1'b1;
    #1;
    `CHK("arst_state", state, 2'd0)
    `CHK("arst_flags", {tick_slide, scroll_en, done}, 3'b000)
    `CHK("arst_loop", loop_cnt, 8'd0)
    @(negedge clk);
    rst = 1'b0;

    // 3. run to completion
    pulse(ST);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      wait_tick(n);
      if (n != 4) bad++;
    end
    `CHK("run_periods_bad", bad, 0)
    `CHK("last_tick_win", win_idx, 4'd11)
    @(negedge clk);
    `CHK("done_loop", loop_cnt, 8'd2)
    `CHK("done_state", state, 2'd3)
    `CHK("done_flag", done, 1'b1)
    `CHK("done_win", win_idx, 4'd0)
    count_ticks(200, k);
    `CHK("done_ticks", k, 0)
    pulse(ST);
    `CHK("restart_state", state, 2'd1)
    `CHK("restart_loop", loop_cnt, 8'd0)

    // 4. pause and step
    repeat (2) @(negedge clk);
    pulse(PA);
    `CHK("pause_state", state, 2'd2)
    `CHK("pause_en", scroll_en, 1'b0)
    count_ticks(100, k);
    `CHK("pause_ticks", k, 0)
    step_once();
    step_once();
    step_once();
    `CHK("step_win", win_idx, 4'd3)
    pulse(PA | STEP);
    `CHK("resume_state", state, 2'd1)
    `CHK("resume_no_step", tick_slide, 1'b0)
    wait_tick(n);
    `CHK("resume_remaining", n, 2)

    // 5. speed control
    pulse(DN); pulse(DN); pulse(DN);
    `CHK("speed_min", speed, 2'd0)
    wait_tick(n);
    `CHK("slow_first", n, 32)
    wait_tick(n);
    `CHK("slow_period", n, 32)
    pulse(DN);
    `CHK("speed_sat0", speed, 2'd0)
    wait_tick(n);
    `CHK("sat_no_clear", n, 31)
    pulse(UP); pulse(UP); pulse(UP); pulse(UP); pulse(UP);
    `CHK("speed_max", speed, 2'd3)
    wait_tick(n);
    `CHK("fast_after_sat", n, 2)
    wait_tick(n);
    `CHK("fast_period", n, 4)
    pulse(UP | DN);
    `CHK("speed_both", speed, 2'd3)
    wait_tick(n);
    `CHK("both_no_clear", n, 3)

    // 6. start ignored in RUN, stop, step wraps
    pulse(ST);
    `CHK("start_ign_state", state, 2'd1)
    `CHK("start_ign_loop", loop_cnt, 8'd0)
    wait_tick(n);
    `CHK("start_ign_presc", n, 3)
    repeat (3) @(negedge clk);
    w0 = win_idx;
    pulse(SP);
    `CHK("stop_state", state, 2'd0)
    `CHK("stop_flags", {tick_slide, scroll_en}, 2'b00)
    `CHK("stop_loop", loop_cnt, 8'd0)
    count_ticks(20, k);
    `CHK("stop_ticks", k, 0)
    `CHK("stop_win", win_idx, w0)

    pulse(ST);
    pulse(PA);
    `CHK("pause2_state", state, 2'd2)
    for (int i = 0; i < 12 && win_idx != 4'd11; i++) step_once();
    `CHK("pre_wrap_loop", loop_cnt, 8'd0)
    step_once();
    `CHK("step_wrap_loop", loop_cnt, 8'd1)
    `CHK("step_wrap_state", state, 2'd2)
    `CHK("step_wrap_win", win_idx, 4'd0)
    for (int i = 0; i < 11; i++) step_once();
    pulse(STEP);
    @(negedge clk);
    `CHK("step_done_loop", loop_cnt, 8'd2)
    `CHK("step_done_state", state, 2'd3)
    `CHK("step_done_flag", done, 1'b1)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
